// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter in front of a single FIFO write port.
// An owner keeps the port for up to MAX_BURST beats; stalls on full without timeout.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_in,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            accept,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [IDXW-1:0]    nxt_ptr, pick_base, pick_idx;
  logic               pick_hit, burst_end;

  assign nxt_ptr = (int'(owner_q) == NUM_REQ-1) ? '0 : owner_q + 1'b1;

  // In BURST the search already uses the post-burst pointer, so the same
  // picker serves both the idle pick and the same-cycle re-arbitration.
  // A low owner bit is already absent from req, so no extra masking is needed.
  always_comb begin
    int j;
    pick_base = (state_q == BURST) ? nxt_ptr : rr_ptr_q;
    pick_hit  = 1'b0;
    pick_idx  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = int'(pick_base) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[IDXW'(j)]) begin
        pick_hit = 1'b1;
        pick_idx = IDXW'(j);
      end
    end
  end

  assign fifo_wr_en = (state_q == BURST) && req[owner_q] && !full;
  assign burst_end  = (state_q == BURST) &&
                      ((fifo_wr_en && cnt_q == CW'(MAX_BURST-1)) || !req[owner_q]);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          state_d = BURST;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (fifo_wr_en) cnt_d = cnt_q + 1'b1;
        if (burst_end) begin
          rr_ptr_d = nxt_ptr;
          cnt_d    = '0;
          if (pick_hit) owner_d = pick_idx;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == BURST) grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  assign grant        = grant_q;
  assign accept       = fifo_wr_en ? grant_q : '0;
  assign fifo_wr_data = (|grant_q) ? wr_data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an owner/beat/pointer model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   wr_data_in = '0;
  logic             full = 1'b0;
  logic [N-1:0]     grant, accept;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_wr_data;

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .wr_data_in(wr_data_in), .full(full),
    .grant(grant), .accept(accept), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 = nobody), beats written in this burst, round-robin start.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  bit m_fin;

  function automatic int pick_from(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      m_owner = pick_from(m_ptr, req);
      m_beats = 0;
    end else begin
      m_fin = 0;
      if (req[m_owner] && !full) begin
        m_beats++;
        if (m_beats == MB) m_fin = 1;
      end else if (!req[m_owner]) begin
        m_fin = 1;
      end
      if (m_fin) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick_from(m_ptr, req);
        m_beats = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, ea;
    logic         ew;
    logic [W-1:0] ed;
    eg = '0; ea = '0; ew = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ew = req[m_owner] && !full;
      ea = ew ? eg : '0;
      ed = wr_data_in[m_owner*W +: W];
    end
    chk("grant", grant, eg);
    chk("fifo_wr_en", fifo_wr_en, ew);
    chk("accept", accept, ea);
    chk("fifo_wr_data", fifo_wr_data, ed);
  end

  initial begin
    int cnt;
    logic [N-1:0] eg;
    for (int i = 0; i < N; i++) wr_data_in[i*W +: W] = 8'(8'hA0 + i);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; req = 4'b0001;

    // Sole requester: grant from cycle 1, re-granted with no gap.
    @(negedge clk); chk("idle_cycle0_grant", grant, 4'b0000);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (fifo_wr_en) cnt++;
    end
    chk("sole_writes_by_cycle5", cnt, 5);
    chk("sole_grant", grant, 4'b0001);

    // Reset, then everyone requests: owners 0,1,2,3 with 4 beats each.
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1; req = 4'b1111;
    @(negedge clk); chk("rr_idle_cycle0", grant, 4'b0000);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      eg = '0; eg[(i / 4) % N] = 1'b1;
      chk("rr_owner_seq", grant, eg);
      chk("rr_wr_en_continuous", fifo_wr_en, 1'b1);
      chk("rr_data", fifo_wr_data, 8'(8'hA0 + (i / 4) % N));
    end

    // Asynchronous reset mid-burst of owner 3, then requester 0 is favoured.
    @(posedge clk); #3 reset = 1'b0;
    #1 chk("async_rst_grant", grant, 4'b0000);
    chk("async_rst_wr_en", fifo_wr_en, 1'b0);
    chk("async_rst_data", fifo_wr_data, 8'h00);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); chk("post_rst_idle", grant, 4'b0000);
    @(negedge clk); chk("post_rst_owner0", grant, 4'b0001);

    // Full stalls hold the owner with no writes.
    @(posedge clk); #1 full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_hold_grant", grant, 4'b0001);
      chk("full_hold_wr_en", fifo_wr_en, 1'b0);
    end

    // Owner drops req: ends burst without a write, next requester takes over.
    @(posedge clk); #1 full = 1'b0; req = 4'b1010;
    @(negedge clk); chk("drop_no_write", fifo_wr_en, 1'b0);
    @(negedge clk); chk("drop_new_owner1", grant, 4'b0010);
    @(negedge clk); chk("owner1_beat1", fifo_wr_en, 1'b1);
    @(posedge clk); #1 req = 4'b1000;
    @(negedge clk); chk("owner1_drop_no_write", fifo_wr_en, 1'b0);
    @(negedge clk); chk("owner3_after_drop", grant, 4'b1000);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 9) < 7);
      full = ($urandom_range(0, 3) == 0);
      wr_data_in = $urandom();
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
      end
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
